// File: rtl/serial_frame_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Every bit is held on tx for BIT_CYCLES clocks; done pulses once after the stop bit.
module serial_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              busy,
    output logic              tx,
    output logic              done
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shreg;
    logic              r_parity;
    logic [CNT_W-1:0]  r_cyc;
    logic [IDX_W-1:0]  r_idx;
    logic              r_tx;
    logic              r_done;

    state_t            w_state_next;
    logic [DATA_W-1:0] w_shreg_next;
    logic              w_parity_next;
    logic [CNT_W-1:0]  w_cyc_next;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_tx_next;
    logic              w_done_next;
    logic              w_bit_end;

    assign w_bit_end = (r_cyc == CNT_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_shreg_next  = r_shreg;
        w_parity_next = r_parity;
        w_idx_next    = r_idx;
        w_done_next   = 1'b0;
        // The cycle counter only runs inside a frame and wraps on every bit boundary.
        if (r_state == S_IDLE || w_bit_end) begin
            w_cyc_next = '0;
        end else begin
            w_cyc_next = r_cyc + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next  = S_START;
                    w_shreg_next  = data;
                    w_parity_next = ^data;
                    w_idx_next    = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_idx_next   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_shreg_next = r_shreg >> 1;
                        w_idx_next   = r_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // tx is registered, so it is derived from the state being entered, not the current one.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shreg_next[0];
            S_PARITY: w_tx_next = w_parity_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_parity <= 1'b0;
            r_cyc    <= '0;
            r_idx    <= '0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shreg  <= w_shreg_next;
            r_parity <= w_parity_next;
            r_cyc    <= w_cyc_next;
            r_idx    <= w_idx_next;
            r_tx     <= w_tx_next;
            r_done   <= w_done_next;
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign ready = ~busy;
    assign tx    = r_tx;
    assign done  = r_done;

endmodule
